lvds_frame_scheduler: RTL and testbench
=======================================

# lvds_frame_scheduler

Sequences the 8-bit LVDS byte serializer on behalf of several packet sources. Arbitrates round-robin between `NUM_REQ` byte-stream requesters, then drives the serializer one byte at a time. Each frame is sent as an unencoded start flag 0x7E, 8b/10b-encoded payload bytes, and an unencoded end flag 0x7E. Sits between the TX packet buffers and the serializer in the serdes stream path.

## Interface

**Parameters**
- `NUM_REQ`, 2: number of requesters (2..4).
- `MAX_LEN`, 256: maximum payload bytes per frame (1..1024).
- `ACK_TIMEOUT`, 16: cycles to wait for serializer busy to rise before re-issuing.

**Ports**
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid_i` in NUM_REQ: requester r has a byte available.
- `req_data_i` in NUM_REQ*8: byte of requester r is at `[r*8+7:r*8]`.
- `req_last_i` in NUM_REQ: byte is the last of its packet.
- `req_ready_o` out NUM_REQ: one-cycle pulse; byte of requester r consumed.
- `grant_o` out NUM_REQ: one-hot owner of the current frame; 0 when idle.
- `ser_data_o` out 8: byte to the serializer.
- `ser_flag_o` out 1: 1 means send `ser_data_o` unencoded (flag byte).
- `ser_start_o` out 1: one-cycle issue pulse to the serializer.
- `ser_busy_i` in 1: serializer busy.
- `frame_active_o` out 1: high from SOF issue until EOF completes.
- `trunc_o` out 1: one-cycle pulse; frame closed at `MAX_LEN`.
- `timeout_o` out 1: one-cycle pulse; byte re-issued after an ack timeout.

## Operation

**Frame FSM:** IDLE → ARB → SOF → DATA → EOF → IDLE.
- **IDLE:** waits for any `req_valid_i`.
- **ARB:** round-robin pick.
  - Search starts at (last grantee + 1) mod NUM_REQ; the pointer resets to requester 0.
  - Registers `grant_o`.
- **SOF:** issues 0x7E with flag=1.
- **DATA:** issues granted bytes with flag=0.
  - `req_ready_o[g]` pulses in the cycle the byte is captured into `ser_data_o`.
  - Valid low on the granted requester stalls DATA. The serializer idles; the frame stays open with no time limit.
  - The byte with last=1, or the `MAX_LEN`-th byte, moves the FSM to EOF after that byte completes.
  - Reaching `MAX_LEN` without last pulses `trunc_o`. The remaining bytes of that packet start a new frame after re-arbitration.
- **EOF:** issues 0x7E with flag=1. Then `grant_o` clears and the FSM returns to IDLE.

**Byte sub-FSM:** ISSUE → WAIT_ACK → WAIT_DONE.
- **ISSUE:** `ser_start_o`=1 for 1 cycle. `ser_data_o` and `ser_flag_o` are stable from ISSUE until WAIT_DONE exits.
- **WAIT_ACK:** waits for `ser_busy_i`=1.
  - If busy has not risen after `ACK_TIMEOUT` cycles, return to ISSUE and pulse `timeout_o`.
  - The byte is not re-consumed from the requester.
- **WAIT_DONE:** waits for `ser_busy_i`=0, then one extra cycle so the serializer can pass through its re-arm state. The byte is then complete.

**Payload 0x7E:** sent encoded (flag=0), so no escaping is needed.

**Payload counter:** 11 bits, cleared in ARB.

**Reset:** asserting `reset_n` mid-frame aborts immediately. No EOF is sent; the next frame starts clean.

## Timing

- **Reset values:** all outputs 0; FSMs in IDLE/ISSUE; round-robin pointer at 0.
- **Frame start:** `req_valid_i` high in IDLE gives ARB on the next cycle and `ser_start_o` (SOF) one cycle after ARB, i.e. 2 cycles.
- **Consecutive bytes:** next `ser_start_o` comes ≥1 cycle after busy falls. With a 10-cycle serializer busy window: 1 issue + 1 ack + 10 busy + 1 re-arm = 13 cycles per byte.
- **`req_ready_o`:** coincides with `ser_start_o` of that payload byte.
- **Simultaneous requests:** resolved only in ARB. Requests arriving mid-frame wait; there is no preemption.
- **Busy high in IDLE or at ISSUE:** ISSUE is delayed until busy is 0.

## Configuration

`LVDS_SCHED_IDLE_FILL_EN`
- **Defined:** in IDLE with no valid request, the scheduler continuously issues flag 0x7E bytes through the byte sub-FSM to keep the link alive. `grant_o` stays 0 and `frame_active_o` stays 0. A request arriving during a fill byte waits for that byte to complete, then goes to ARB.
- **Undefined:** `ser_start_o` stays low in IDLE.

## Structure

**Package `lvds_sched_pkg`:**
- `FLAG_BYTE` = 8'h7E.
- Frame-state and byte-state enums.

**Sub-module `lvds_byte_issuer`:**
- Contains the ISSUE/WAIT_ACK/WAIT_DONE sub-FSM and the timeout counter.
- Inputs: `go`, data, flag. Outputs: `done`, `timeout`.
- The top holds the frame FSM, arbiter and counters.

## Test plan

- **Single packet:** requester 0 sends 3 bytes {0x11,0x22,0x33 last} → serializer sees 0x7E(f=1), 0x11, 0x22, 0x33 (f=0), 0x7E(f=1); `req_ready_o[0]` pulses 3 times; `frame_active_o` spans all 5.
- **Round-robin:** NUM_REQ=2, both requesters continuously valid with 1-byte packets → grants alternate 0,1,0,1 and no frame interleaves another.
- **Truncation:** MAX_LEN=4, 6-byte packet → frame of 4 payload bytes, `trunc_o` pulse, then a new frame of 2 bytes.
- **Ack timeout:** model suppresses busy for 20 cycles on the first byte → `timeout_o` pulses once at cycle 16 of WAIT_ACK; the byte is re-issued and `req_ready_o` pulsed only once.
- **Stall and payload 0x7E:** payload contains 0x7E and valid drops for 30 cycles mid-packet → 0x7E sent with f=0; frame resumes with no extra bytes.
- **Reset:** `reset_n` low mid-DATA → all outputs 0 asynchronously; after release, the pending request starts at SOF. With the macro defined, idle 0x7E fill appears only when no request is pending.

Source files
------------

// File: rtl/lvds_sched_pkg.sv
// Shared constants and state encodings for the LVDS frame scheduler.
package lvds_sched_pkg;

  localparam logic [7:0] FLAG_BYTE = 8'h7E;

  typedef enum logic [2:0] {
    F_IDLE,
    F_ARB,
    F_SOF,
    F_DATA,
    F_EOF
  } frame_state_e;

  // The serializer re-arm cycle is the first cycle spent back in B_ISSUE.
  typedef enum logic [1:0] {
    B_ISSUE,
    B_WAIT_ACK,
    B_WAIT_DONE
  } byte_state_e;

endpackage

// File: rtl/lvds_byte_issuer.sv
// Single-byte handshake with the LVDS serializer: issue, wait for busy to
// rise (re-issuing the held byte on timeout), wait for busy to fall.
module lvds_byte_issuer
  import lvds_sched_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       go,
  input  logic [7:0] data,
  input  logic       flag,
  input  logic       ser_busy_i,
  output logic       accept,
  output logic       done,
  output logic       timeout,
  output logic       ser_start_o,
  output logic [7:0] ser_data_o,
  output logic       ser_flag_o
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  byte_state_e   state;
  logic [TW-1:0] ack_cnt;
  logic          retry;
  logic          launch;

  // A fresh byte is taken only when no re-issue is pending; a retry reuses the held byte.
  always_comb begin
    launch = (state == B_ISSUE) && (go || retry) && !ser_busy_i;
    accept = (state == B_ISSUE) && go && !retry && !ser_busy_i;
    done   = (state == B_WAIT_DONE) && !ser_busy_i;
  end

  // Byte sub-FSM with registered serializer outputs and ack timeout counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= B_ISSUE;
      ack_cnt     <= '0;
      retry       <= 1'b0;
      ser_start_o <= 1'b0;
      ser_data_o  <= '0;
      ser_flag_o  <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      ser_start_o <= 1'b0;
      timeout     <= 1'b0;
      case (state)
        B_ISSUE: begin
          if (launch) begin
            ser_start_o <= 1'b1;
            ack_cnt     <= '0;
            retry       <= 1'b0;
            state       <= B_WAIT_ACK;
            if (!retry) begin
              ser_data_o <= data;
              ser_flag_o <= flag;
            end
          end
        end
        B_WAIT_ACK: begin
          if (ser_busy_i) begin
            state <= B_WAIT_DONE;
          end else if (ack_cnt == TW'(ACK_TIMEOUT - 1)) begin
            retry   <= 1'b1;
            timeout <= 1'b1;
            state   <= B_ISSUE;
          end else begin
            ack_cnt <= ack_cnt + TW'(1);
          end
        end
        B_WAIT_DONE: begin
          if (!ser_busy_i) state <= B_ISSUE;
        end
        default: state <= B_ISSUE;
      endcase
    end
  end

endmodule

// File: rtl/lvds_frame_scheduler.sv
// Round-robin frame scheduler feeding the LVDS byte serializer.
// Frames: flag 0x7E, encoded payload, flag 0x7E.
// Optional: LVDS_SCHED_IDLE_FILL_EN sends flag bytes while idle to keep the link alive.
module lvds_frame_scheduler
  import lvds_sched_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int MAX_LEN     = 256,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ*8-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic [7:0]           ser_data_o,
  output logic                 ser_flag_o,
  output logic                 ser_start_o,
  input  logic                 ser_busy_i,
  output logic                 frame_active_o,
  output logic                 trunc_o,
  output logic                 timeout_o
);

  localparam int IW = $clog2(NUM_REQ);

  frame_state_e  state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] gidx;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] cand;
  logic [IW-1:0] rr_nxt;
  logic          pick_vld;
  logic [10:0]   byte_cnt;
  logic          inflight;
  logic          byte_last;
  logic          byte_trunc;
  logic          go;
  logic [7:0]    data_sel;
  logic          flag_sel;
  logic          accept;
  logic          done;

  // Round-robin search from rr_ptr; lowest offset with valid wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IW'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid_i[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
    rr_nxt = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + IW'(1);
  end

  // Byte source per frame state; SOF is offered already in ARB to save a cycle.
  always_comb begin
    go       = 1'b0;
    data_sel = FLAG_BYTE;
    flag_sel = 1'b1;
    case (state)
      F_IDLE: begin
`ifdef LVDS_SCHED_IDLE_FILL_EN
        go = !(|req_valid_i) && !inflight;
`else
        go = 1'b0;
`endif
      end
      F_ARB:  go = pick_vld && !inflight;
      F_SOF:  go = !inflight;
      F_EOF:  go = !inflight;
      F_DATA: begin
        go       = req_valid_i[gidx] && !inflight;
        data_sel = req_data_i[gidx*8 +: 8];
        flag_sel = 1'b0;
      end
      default: go = 1'b0;
    endcase
  end

  lvds_byte_issuer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_issuer (
    .clk         (clk),
    .reset_n     (reset_n),
    .go          (go),
    .data        (data_sel),
    .flag        (flag_sel),
    .ser_busy_i  (ser_busy_i),
    .accept      (accept),
    .done        (done),
    .timeout     (timeout_o),
    .ser_start_o (ser_start_o),
    .ser_data_o  (ser_data_o),
    .ser_flag_o  (ser_flag_o)
  );

  // Frame FSM, grant/pointer, payload counter and registered status pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= F_IDLE;
      rr_ptr         <= '0;
      gidx           <= '0;
      grant_o        <= '0;
      byte_cnt       <= '0;
      inflight       <= 1'b0;
      byte_last      <= 1'b0;
      byte_trunc     <= 1'b0;
      req_ready_o    <= '0;
      frame_active_o <= 1'b0;
      trunc_o        <= 1'b0;
    end else begin
      req_ready_o <= '0;
      trunc_o     <= 1'b0;
      if (accept)    inflight <= 1'b1;
      else if (done) inflight <= 1'b0;

      case (state)
        F_IDLE: begin
          // a fill byte in flight must complete before arbitration
          if (|req_valid_i && !inflight) state <= F_ARB;
        end
        F_ARB: begin
          byte_cnt <= '0;
          if (pick_vld) begin
            gidx    <= pick_idx;
            grant_o <= NUM_REQ'(1) << pick_idx;
            rr_ptr  <= rr_nxt;
            state   <= F_SOF;
            if (accept) frame_active_o <= 1'b1;
          end else begin
            state <= F_IDLE;
          end
        end
        F_SOF: begin
          if (accept) frame_active_o <= 1'b1;
          if (done)   state <= F_DATA;
        end
        F_DATA: begin
          if (accept) begin
            req_ready_o[gidx] <= 1'b1;
            byte_cnt          <= byte_cnt + 11'd1;
            byte_last         <= req_last_i[gidx] || (byte_cnt == 11'(MAX_LEN - 1));
            byte_trunc        <= !req_last_i[gidx] && (byte_cnt == 11'(MAX_LEN - 1));
          end
          if (done && byte_last) begin
            trunc_o <= byte_trunc;
            state   <= F_EOF;
          end
        end
        F_EOF: begin
          if (done) begin
            grant_o        <= '0;
            frame_active_o <= 1'b0;
            state          <= F_IDLE;
          end
        end
        default: state <= F_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lvds_frame_scheduler.sv
// Directed bench for lvds_frame_scheduler (NUM_REQ=2, MAX_LEN=4, ACK_TIMEOUT=16)
// with a 10-cycle-busy serializer model and queue-driven requesters.
module tb_lvds_frame_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid_i;
  logic [15:0] req_data_i;
  logic [1:0]  req_last_i;
  logic [1:0]  req_ready_o;
  logic [1:0]  grant_o;
  logic [7:0]  ser_data_o;
  logic        ser_flag_o;
  logic        ser_start_o;
  logic        ser_busy_i;
  logic        frame_active_o;
  logic        trunc_o;
  logic        timeout_o;

  lvds_frame_scheduler #(.NUM_REQ(2), .MAX_LEN(4), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
    .req_ready_o(req_ready_o), .grant_o(grant_o),
    .ser_data_o(ser_data_o), .ser_flag_o(ser_flag_o), .ser_start_o(ser_start_o),
    .ser_busy_i(ser_busy_i), .frame_active_o(frame_active_o),
    .trunc_o(trunc_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // serializer model: busy for 10 cycles starting the cycle after start
  int   bcnt;
  logic drop_arm = 1'b0;
  logic drop_done = 1'b0;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) bcnt <= 0;
    else if (ser_start_o && !(drop_arm && !drop_done && !ser_flag_o)) bcnt <= 10;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  always @(posedge clk)
    if (ser_start_o && drop_arm && !drop_done && !ser_flag_o) drop_done <= 1'b1;
  assign ser_busy_i = (bcnt != 0);

  // monitor: {grant, frame_active, flag, data} per issued byte
  logic [11:0] log_q[$];
  int          st_q[$];
  int          rdy_cnt[2];
  int          rdy_bad = 0, trunc_cnt = 0, to_cnt = 0, t_to = 0;
  initial begin rdy_cnt[0] = 0; rdy_cnt[1] = 0; end
  always @(negedge clk) begin
    if (ser_start_o) begin
      log_q.push_back({grant_o, frame_active_o, ser_flag_o, ser_data_o});
      st_q.push_back(cyc);
    end
    if (req_ready_o[0]) rdy_cnt[0]++;
    if (req_ready_o[1]) rdy_cnt[1]++;
    if (req_ready_o != 2'b00 && !ser_start_o) rdy_bad++;
    if (trunc_o) trunc_cnt++;
    if (timeout_o) begin to_cnt++; t_to = cyc; end
  end

  // requesters: queues of {last, data}, popped on req_ready
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  int         t_vrise = 0;
  initial begin
    logic [1:0] vn;
    req_valid_i = '0; req_data_i = '0; req_last_i = '0;
    forever begin
      @(negedge clk);
      if (req_ready_o[0] && q0.size() > 0) void'(q0.pop_front());
      if (req_ready_o[1] && q1.size() > 0) void'(q1.pop_front());
      vn = {q1.size() > 0, q0.size() > 0};
      if (req_valid_i == 2'b00 && vn != 2'b00) t_vrise = cyc;
      req_valid_i      = vn;
      req_data_i[7:0]  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
      req_last_i[0]    = (q0.size() > 0) ? q0[0][8] : 1'b0;
      req_data_i[15:8] = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
      req_last_i[1]    = (q1.size() > 0) ? q1[0][8] : 1'b0;
    end
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {15'b0, req_ready_o, grant_o, ser_data_o, ser_flag_o, ser_start_o,
            frame_active_o, trunc_o, timeout_o};
  endfunction

  logic [11:0] exp_q[$];
  task automatic ex(input logic [1:0] g, input logic f, input logic [7:0] d);
    exp_q.push_back({g, 1'b1, f, d});
  endtask

  task automatic wait_log(input string tag, input int n, input int budget);
    int k = 0;
    while (log_q.size() < n && k < budget) begin @(negedge clk); k++; end
    chk({tag, "_wait"}, 32'(log_q.size() >= n), 1);
  endtask

  task automatic check_log(input string tag, input int base);
    chk({tag, "_count"}, log_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < log_q.size())
        chk($sformatf("%s_b%0d", tag, i), 32'(log_q[base+i]), 32'(exp_q[i]));
    exp_q.delete();
  endtask

  task automatic wait_rdy(input string tag, input int r, input int prev);
    int k = 0;
    while (rdy_cnt[r] <= prev && k < 200) begin @(negedge clk); k++; end
    chk({tag, "_rdy_wait"}, 32'(rdy_cnt[r] > prev), 1);
  endtask

  initial begin
    int base, r0, r1, tr0, to0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", outs(), 0);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_no_start", log_q.size(), 0);

    // single 3-byte packet
    base = log_q.size(); r0 = rdy_cnt[0];
    q0.push_back({1'b0, 8'h11}); q0.push_back({1'b0, 8'h22}); q0.push_back({1'b1, 8'h33});
    wait_log("single", base + 5, 200);
    ex(2'b01, 1, 8'h7E); ex(2'b01, 0, 8'h11); ex(2'b01, 0, 8'h22); ex(2'b01, 0, 8'h33); ex(2'b01, 1, 8'h7E);
    if (st_q.size() >= base + 3) begin
      chk("single_sof_latency", st_q[base] - t_vrise, 2);
      chk("single_byte_period", st_q[base+2] - st_q[base+1], 13);
    end
    repeat (20) @(negedge clk);
    check_log("single", base);
    chk("single_ready_cnt", rdy_cnt[0] - r0, 3);
    chk("single_fa_end", frame_active_o, 0);
    chk("single_grant_end", grant_o, 0);

    // round-robin after reset: pointer restarts at requester 0
    reset_n = 1'b0; repeat (2) @(negedge clk); reset_n = 1'b1;
    base = log_q.size();
    q0.push_back({1'b1, 8'hA0}); q0.push_back({1'b1, 8'hA1});
    q1.push_back({1'b1, 8'hB0}); q1.push_back({1'b1, 8'hB1});
    wait_log("rr", base + 12, 400);
    ex(2'b01, 1, 8'h7E); ex(2'b01, 0, 8'hA0); ex(2'b01, 1, 8'h7E);
    ex(2'b10, 1, 8'h7E); ex(2'b10, 0, 8'hB0); ex(2'b10, 1, 8'h7E);
    ex(2'b01, 1, 8'h7E); ex(2'b01, 0, 8'hA1); ex(2'b01, 1, 8'h7E);
    ex(2'b10, 1, 8'h7E); ex(2'b10, 0, 8'hB1); ex(2'b10, 1, 8'h7E);
    repeat (20) @(negedge clk);
    check_log("rr", base);

    // truncation at MAX_LEN=4 with a 6-byte packet
    base = log_q.size(); tr0 = trunc_cnt;
    for (int i = 0; i < 6; i++) q1.push_back({i == 5, 8'hC0 + 8'(i)});
    wait_log("trunc", base + 10, 400);
    ex(2'b10, 1, 8'h7E);
    for (int i = 0; i < 4; i++) ex(2'b10, 0, 8'hC0 + 8'(i));
    ex(2'b10, 1, 8'h7E); ex(2'b10, 1, 8'h7E); ex(2'b10, 0, 8'hC4); ex(2'b10, 0, 8'hC5); ex(2'b10, 1, 8'h7E);
    repeat (20) @(negedge clk);
    check_log("trunc", base);
    chk("trunc_pulses", trunc_cnt - tr0, 1);

    // ack timeout on first payload byte
    drop_arm = 1'b1;
    base = log_q.size(); r0 = rdy_cnt[0]; to0 = to_cnt;
    q0.push_back({1'b0, 8'hD0}); q0.push_back({1'b1, 8'hD1});
    wait_log("tmo", base + 5, 300);
    ex(2'b01, 1, 8'h7E); ex(2'b01, 0, 8'hD0); ex(2'b01, 0, 8'hD0); ex(2'b01, 0, 8'hD1); ex(2'b01, 1, 8'h7E);
    repeat (20) @(negedge clk);
    check_log("tmo", base);
    chk("tmo_pulses", to_cnt - to0, 1);
    chk("tmo_ready_cnt", rdy_cnt[0] - r0, 2);
    if (st_q.size() >= base + 2) chk("tmo_delay", t_to - st_q[base+1], 16);
    drop_arm = 1'b0;

    // payload 0x7E and a 30-cycle valid stall mid-packet
    base = log_q.size();
    r0 = rdy_cnt[0];
    q0.push_back({1'b0, 8'h7E});
    wait_rdy("stall", 0, r0);
    repeat (30) @(negedge clk);
    q0.push_back({1'b0, 8'hA5}); q0.push_back({1'b1, 8'h5A});
    wait_log("stall", base + 5, 300);
    ex(2'b01, 1, 8'h7E); ex(2'b01, 0, 8'h7E); ex(2'b01, 0, 8'hA5); ex(2'b01, 0, 8'h5A); ex(2'b01, 1, 8'h7E);
    repeat (30) @(negedge clk);
    if (st_q.size() >= base + 3) chk("stall_gap", 32'(st_q[base+2] - st_q[base+1] > 30), 1);
    check_log("stall", base);

    // asynchronous reset in the middle of DATA
    r1 = rdy_cnt[1];
    q1.push_back({1'b0, 8'hE0}); q1.push_back({1'b0, 8'hE1}); q1.push_back({1'b1, 8'hE2});
    wait_rdy("rstmid", 1, r1);
    repeat (3) @(negedge clk);
    chk("rstmid_fa_before", frame_active_o, 1);
    #2 reset_n = 1'b0;
    #1 chk("rstmid_async_outs", outs(), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    base = log_q.size();
    wait_log("rstmid", base + 4, 300);
    ex(2'b10, 1, 8'h7E); ex(2'b10, 0, 8'hE1); ex(2'b10, 0, 8'hE2); ex(2'b10, 1, 8'h7E);
    repeat (20) @(negedge clk);
    check_log("rstmid", base);

    chk("ready_only_with_start", rdy_bad, 0);
    chk("trunc_total", trunc_cnt, 1);
    chk("timeout_total", to_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
